// File: rtl/rca_result_stage.sv
// Result register stage for a ripple-carry adder: a 2-entry FIFO of sum, carry and status flags.
// Optional self-check of the adder result is enabled by defining RCA_RESULT_CHECK_EN.
module rca_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [15:0]      out_cnt,
  output logic             chk_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
  } entry_t;

  state_t      state_reg, state_next;
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [15:0] cnt_reg;
  logic        push, pop;
  entry_t      new_entry;
  entry_t      head;

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry      = '0;
    new_entry.sum  = in_sum;
    new_entry.cout = in_cout;
    new_entry.zero = (in_sum == '0);
    new_entry.neg  = in_sum[WIDTH-1];
    new_entry.ovf  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (in_sum[WIDTH-1] != in_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Each slot is its own register so reset can clear it and out_* read zero afterwards.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    entry_t entry_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                entry_reg <= '0;
      else if (push && (wr_ptr_reg == (gi != 0))) entry_reg <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 16'h0000;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        cnt_reg    <= cnt_reg + 16'h0001;
      end
    end
  end

  assign head     = rd_ptr_reg ? g_slot[1].entry_reg : g_slot[0].entry_reg;
  assign out_sum  = head.sum;
  assign out_cout = head.cout;
  assign out_zero = head.zero;
  assign out_neg  = head.neg;
  assign out_ovf  = head.ovf;
  assign out_cnt  = cnt_reg;

`ifdef RCA_RESULT_CHECK_EN
  logic [WIDTH:0] ref_sum;
  logic           chk_err_reg;

  assign ref_sum = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      chk_err_reg <= 1'b0;
    else if (push && (ref_sum != {in_cout, in_sum})) chk_err_reg <= 1'b1;
  end

  assign chk_err = chk_err_reg;
`else
  logic unused_cin;
  assign unused_cin = in_cin;
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rca_result_stage.sv
// Scoreboard bench for rca_result_stage: random and directed adder results against a queue model.
module tb_rca_result_stage;
  localparam int W = 32;
`ifdef RCA_RESULT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin, in_cout;
  logic [W-1:0] in_a, in_b, in_sum;
  logic         out_valid, out_ready, out_cout, out_zero, out_neg, out_ovf;
  logic [W-1:0] out_sum;
  logic [15:0]  out_cnt;
  logic         chk_err;

  int           checks = 0;
  int           errors = 0;
  logic [W+3:0] exp_q[$];
  logic [15:0]  cnt_model = 16'h0;
  logic         chk_model = 1'b0;
  logic         chk_pend  = 1'b0;
  logic         acc;

  rca_result_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf), .out_cnt(out_cnt),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected record {sum, cout, zero, neg, ovf} derived from the flag rules.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, b, s, input logic co);
    logic zero, neg, ovf;
    zero = (s == 0);
    neg  = s[W-1];
    ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {s, co, zero, neg, ovf};
  endfunction

  task automatic step(input logic v, input logic [W-1:0] a, b, input logic cin,
                      input logic [W-1:0] s, input logic co, input logic ordy, output logic accepted);
    longint unsigned full;
    @(posedge clk); #1;
    chk_model = chk_model | chk_pend;
    chk_pend  = 1'b0;
    in_valid = v; in_a = a; in_b = b; in_cin = cin; in_sum = s; in_cout = co; out_ready = ordy;
    accepted = v && in_ready;
    if (accepted) begin
      exp_q.push_back(model(a, b, s, co));
      full = longint'(a) + longint'(b) + longint'(cin);
      if (CHECK_EN && (full != {31'b0, co, s})) chk_pend = 1'b1;
      $display("push a=%h b=%h cin=%0d sum=%h cout=%0d", a, b, cin, s, co);
    end
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, ordy, a);
  endtask

  task automatic push_hold(input logic [W-1:0] a, b, input logic cin,
                           input logic [W-1:0] s, input logic co, input logic ordy);
    logic a_ok;
    int n;
    a_ok = 1'b0;
    n = 0;
    while (!a_ok && n < 20) begin
      step(1'b1, a, b, cin, s, co, ordy, a_ok);
      n++;
    end
    if (!a_ok) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    idle(1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    cnt_model = 16'h0; chk_model = 1'b0; chk_pend = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_out_flags", {out_sum, out_cout, out_zero, out_neg, out_ovf}, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares the presented head against the scoreboard front on every valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("chk_err", chk_err, chk_model);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_sum, 0);
        end else begin
          check("entry", {out_sum, out_cout, out_zero, out_neg, out_ovf}, exp_q[0]);
          check("out_cnt", out_cnt, cnt_model);
          if (out_ready) begin
            $display("pop sum=%h cout=%0d z=%0d n=%0d v=%0d cnt=%0d",
                     out_sum, out_cout, out_zero, out_neg, out_ovf, out_cnt);
            void'(exp_q.pop_front());
            cnt_model = cnt_model + 16'h1;
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a, b, s;
    logic         cin, co, v, ordy;
    logic [W:0]   full;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sum = '0; in_cout = 1'b0;
    #3;
    check("init_out_valid", out_valid, 0);
    check("init_in_ready", in_ready, 1);
    check("init_out_data", {out_sum, out_cout, out_zero, out_neg, out_ovf, out_cnt}, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Basic latency-1 transfer and count.
    step(1'b1, 32'h00520112, 32'h00445566, 1'b1, 32'h00965679, 1'b0, 1'b1, acc);
    idle(1'b1);
    check("lat1_valid", out_valid, 1);
    check("lat1_sum", out_sum, 32'h00965679);
    check("lat1_flags", {out_cout, out_zero, out_neg, out_ovf}, 4'b0000);
    drain();
    check("cnt_after_one", out_cnt, 1);

    // Overflow into the sign bit, then a wrap to zero with carry out.
    push_hold(32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1);
    push_hold(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1);
    drain();

    // Back-pressure: third push is held until space frees, order preserved.
    do_reset();
    push_hold(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0);
    push_hold(32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0);
    step(1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h00000300, 1'b0, 1'b0, acc);
    check("full_in_ready", in_ready, 0);
    check("full_third_held", acc, 0);
    step(1'b1, 32'h00000100, 32'h00000200, 1'b0, 32'h00000300, 1'b0, 1'b0, acc);
    check("full_still_held", acc, 0);
    push_hold(32'h00000100, 32'h00000200, 1'b0, 32'h00000300, 1'b0, 1'b1);
    drain();
    check("cnt_after_three", out_cnt, 3);

    // Reset while FULL.
    push_hold(32'h00000004, 32'h00000004, 1'b0, 32'h00000008, 1'b0, 1'b0);
    push_hold(32'h00000005, 32'h00000005, 1'b0, 32'h0000000A, 1'b0, 1'b0);
    idle(1'b0);
    check("pre_reset_full", in_ready, 0);
    do_reset();

    // Wrong adder result: sticky error only when the checker is built in.
    push_hold(32'h00000001, 32'h00000001, 1'b0, 32'h00000003, 1'b0, 1'b1);
    idle(1'b1);
    check("chk_err_set", chk_err, CHECK_EN);
    push_hold(32'h00000002, 32'h00000002, 1'b0, 32'h00000004, 1'b0, 1'b1);
    drain();
    check("chk_err_sticky", chk_err, CHECK_EN);
    do_reset();

    // Randomized traffic with boundary-biased operands and occasional corrupted sums.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h7FFFFFFF;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      b    = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      cin  = 1'($urandom_range(0, 1));
      full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      if ($urandom_range(0, 49) == 0) full = full ^ (33'h1 << $urandom_range(0, 32));
      s    = full[W-1:0];
      co   = full[W];
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      step(v, a, b, cin, s, co, ordy, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rca_result_stage.md
RCA_RESULT_STAGE -- requirements
Module: rca_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of adder operands and sum.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream adder result valid.
REQ-005 SHALL have port in_ready, output, 1, stage can accept a result this cycle.
REQ-006 SHALL have ports in_a and in_b, input, WIDTH each, adder operands.
REQ-007 SHALL have port in_cin, input, 1, adder carry-in.
REQ-008 SHALL have ports in_sum (input, WIDTH) and in_cout (input, 1), adder sum and carry-out.
REQ-009 SHALL have port out_valid, output, 1, registered result available.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have ports out_sum (output, WIDTH) and out_cout (output, 1), registered sum and carry.
REQ-012 SHALL have ports out_zero, out_neg and out_ovf, output, 1 each: sum==0, sum MSB, signed overflow.
REQ-013 SHALL have port out_cnt, output, 16, count of completed output transfers.
REQ-014 SHALL have port chk_err, output, 1, sticky adder self-check error.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready at a rising clk edge, and SHALL transfer an entry out when out_valid && out_ready.
REQ-016 SHALL buffer accepted entries in a 2-entry FIFO; each entry holds sum, cout, zero, neg and ovf computed at accept time.
REQ-017 SHALL compute flags combinationally from inputs at accept time: zero = (in_sum==0), neg = in_sum[WIDTH-1], ovf = (in_a MSB == in_b MSB) && (in_sum MSB != in_a MSB).
REQ-018 SHALL use occupancy states EMPTY, ONE and FULL, with in_ready = (state != FULL) and out_valid = (state != EMPTY).
REQ-019 SHALL transition EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop.
REQ-020 SHALL present an accepted entry on out_* the cycle after acceptance when the FIFO was EMPTY (latency 1).
REQ-021 SHALL preserve FIFO order: the older entry is presented first.
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL ignore in_valid in FULL, with no overwrite and no loss.
REQ-024 SHALL increment out_cnt by 1 per output transfer, wrapping from 0xFFFF to 0x0000.
REQ-025 SHALL drive out_* as don't-care-free zeros when out_valid is 0 after reset; after that, stale data is permitted while out_valid is 0.

Reset
REQ-026 SHALL, while rst_n is low, immediately force state EMPTY, out_valid 0, in_ready 1, out_sum 0, out_cout 0, out_zero 0, out_neg 0, out_ovf 0, out_cnt 0 and chk_err 0.
REQ-027 SHALL discard buffered entries on reset mid-operation; no transfer occurs in the cycle rst_n is low.

Configuration
REQ-028 SHALL, with macro RCA_RESULT_CHECK_EN defined, compute in_a + in_b + in_cin internally on every accept; a mismatch with {in_cout,in_sum} SHALL set chk_err at that edge, and chk_err SHALL stay set until reset.
REQ-029 SHALL, without RCA_RESULT_CHECK_EN, omit the checker logic and tie chk_err to 0.

Verification
REQ-030 SHALL cover this case: a=0x00520112, b=0x00445566, cin=1, sum=0x00965679, cout=0, out_ready=1 -> next cycle out_valid=1, out_sum=0x00965679, zero=0, neg=0, ovf=0, out_cnt increments to 1.
REQ-031 SHALL cover this case: a=0x7FFFFFFF, b=0x00000000, cin=1, sum=0x80000000 -> ovf=1, neg=1, cout=0, zero=0.
REQ-032 SHALL cover this case: a=0xFFFFFFFF, b=0x00000000, cin=1, sum=0x00000000, cout=1 -> zero=1, cout=1, ovf=0, neg=0.
REQ-033 SHALL cover this case: out_ready=0, three back-to-back pushes -> in_ready=0 after the second accept, the third is held; raising out_ready yields the three results in order, and out_cnt ends at 3.
REQ-034 SHALL cover this case: RCA_RESULT_CHECK_EN defined, push a=1, b=1, cin=0, sum=3 -> chk_err=1 from the next cycle and it remains 1 through later correct pushes until rst_n is pulsed low.
REQ-035 SHALL cover this case: rst_n asserted low in FULL -> out_valid=0 and in_ready=1 immediately, and out_cnt=0.
